move_cmd_sequencer: RTL and testbench

Upstream command stage for the printer step pulse generator. It accepts single-axis move commands (axis, direction, step count) over a valid/ready handshake and buffers them in a small FIFO. It then executes them one at a time by driving the `x/y/z_dir` and `x/y/z_step` level inputs of the pulse generator. Each step enable is held for exactly `steps × pSTEP_PERIOD` cycles, followed by an all-low gap so the generator's counters restart cleanly.

---
 rtl/move_cmd_sequencer.sv | 175 +++++++++++++++++
 tb/tb_move_cmd_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_cmd_sequencer.sv
// move_cmd_sequencer
//   Command stage ahead of the step pulse generator. Single-axis move commands
//   (axis, dir, steps) are queued in a small FIFO. They are then executed one
//   at a time by holding the selected axis step enable for
//   steps * pSTEP_PERIOD cycles. Each move is followed by pGAP all-low cycles.
//
//   Optional feature macro: MOVE_SEQ_ABORT_EN adds the synchronous abort input.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   cmd_valid / cmd_ready        command handshake (ready = FIFO not full)
//   cmd_axis, cmd_dir, cmd_steps command fields (axis 3 = dwell)
//   x/y/z_dir, x/y/z_step        level controls to the pulse generator
//   busy                         registered: FSM active or commands queued
//   move_done                    one-cycle pulse as a command completes
//   fifo_level                   number of queued commands
//   abort                        (MOVE_SEQ_ABORT_EN only) flush and stop
//
// state  | meaning
// S_IDLE | waiting; pops FIFO head when not empty
// S_RUN  | step enable held for the selected axis (or dwell)
// S_GAP  | all step enables low for pGAP cycles
module move_cmd_sequencer #(
  parameter int pSTEP_PERIOD = 80000,
  parameter int pGAP         = 4,
  parameter int pDEPTH       = 8,
  parameter int pSTEPS_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_axis,
  input  logic                      cmd_dir,
  input  logic [pSTEPS_W-1:0]       cmd_steps,
  output logic                      x_dir,
  output logic                      x_step,
  output logic                      y_dir,
  output logic                      y_step,
  output logic                      z_dir,
  output logic                      z_step,
  output logic                      busy,
  output logic                      move_done,
  output logic [$clog2(pDEPTH):0]   fifo_level
`ifdef MOVE_SEQ_ABORT_EN
  ,
  input  logic                      abort
`endif
);

  localparam int AW = $clog2(pDEPTH);
  localparam int PW = $clog2(pSTEP_PERIOD);
  localparam int GW = $clog2(pGAP + 1);
  localparam int EW = 3 + pSTEPS_W;

  localparam logic [PW-1:0]       PER_LAST = PW'(pSTEP_PERIOD - 1);
  localparam logic [GW-1:0]       GAP_LOAD = GW'(pGAP - 1);
  localparam logic [pSTEPS_W-1:0] STEP_ONE = pSTEPS_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  state_t               state;
  logic [EW-1:0]        mem [pDEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 empty, full, push, pop, abort_i;
  logic [EW-1:0]        head;
  logic [1:0]           head_axis;
  logic                 head_dir;
  logic [pSTEPS_W-1:0]  head_steps;
  logic [pSTEPS_W-1:0]  step_cnt;
  logic [PW-1:0]        per_cnt;
  logic [GW-1:0]        gap_cnt;

`ifdef MOVE_SEQ_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_level = wr_ptr - rd_ptr;
  assign cmd_ready  = !full;

  assign push = cmd_valid && !full && !abort_i;
  assign pop  = (state == S_IDLE) && !empty && !abort_i;

  assign head       = mem[rd_ptr[AW-1:0]];
  assign head_axis  = head[EW-1 -: 2];
  assign head_dir   = head[EW-3];
  assign head_steps = head[pSTEPS_W-1:0];

  // Combinational so the zero-step completion lands on the pop cycle itself.
  assign move_done = !abort_i &&
                     (((state == S_RUN) && (per_cnt == PER_LAST) && (step_cnt == STEP_ONE)) ||
                      (pop && (head_steps == '0)));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_axis, cmd_dir, cmd_steps};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (abort_i) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      step_cnt <= '0;
      per_cnt  <= '0;
      gap_cnt  <= '0;
      x_step   <= 1'b0;
      y_step   <= 1'b0;
      z_step   <= 1'b0;
      x_dir    <= 1'b0;
      y_dir    <= 1'b0;
      z_dir    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      busy <= (state != S_IDLE) || !empty;
      if (abort_i) begin
        state  <= S_IDLE;
        x_step <= 1'b0;
        y_step <= 1'b0;
        z_step <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (pop && (head_steps != '0)) begin
              step_cnt <= head_steps;
              per_cnt  <= '0;
              state    <= S_RUN;
              case (head_axis)
                2'd0: begin x_step <= 1'b1; x_dir <= head_dir; end
                2'd1: begin y_step <= 1'b1; y_dir <= head_dir; end
                2'd2: begin z_step <= 1'b1; z_dir <= head_dir; end
                default: ;  // dwell: timing only
              endcase
            end
          end
          S_RUN: begin
            if (per_cnt == PER_LAST) begin
              per_cnt <= '0;
              if (step_cnt != '0) step_cnt <= step_cnt - 1'b1;
              if (step_cnt <= STEP_ONE) begin
                state   <= S_GAP;
                gap_cnt <= GAP_LOAD;
                x_step  <= 1'b0;
                y_step  <= 1'b0;
                z_step  <= 1'b0;
              end
            end else begin
              per_cnt <= per_cnt + 1'b1;
            end
          end
          S_GAP: begin
            if (gap_cnt == '0) state <= S_IDLE;
            else               gap_cnt <= gap_cnt - 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_cmd_sequencer.sv
module tb_move_cmd_sequencer;

  localparam int P  = 10;
  localparam int G  = 4;
  localparam int D  = 4;
  localparam int SW = 16;
  localparam int RN = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_axis;
  logic          cmd_dir;
  logic [SW-1:0] cmd_steps;
  logic          x_dir, x_step, y_dir, y_step, z_dir, z_step;
  logic          busy, move_done;
  logic [2:0]    fifo_level;
`ifdef MOVE_SEQ_ABORT_EN
  logic          abort;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  move_cmd_sequencer #(
    .pSTEP_PERIOD(P), .pGAP(G), .pDEPTH(D), .pSTEPS_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_axis(cmd_axis), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
    .x_dir(x_dir), .x_step(x_step), .y_dir(y_dir), .y_step(y_step),
    .z_dir(z_dir), .z_step(z_step),
    .busy(busy), .move_done(move_done), .fifo_level(fifo_level)
`ifdef MOVE_SEQ_ABORT_EN
    , .abort(abort)
`endif
  );

  // Per-cycle recorder, sampled on the falling edge.
  // bit: 0 xs, 1 xd, 2 ys, 3 yd, 4 zs, 5 zd, 6 done, 7 busy
  logic [7:0] samp [RN];
  logic [2:0] lvl  [RN];
  int ncyc = 0;

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    samp[ncyc % RN] = {busy, move_done, z_dir, z_step, y_dir, y_step, x_dir, x_step};
    lvl[ncyc % RN]  = fifo_level;
  end

  function automatic logic sbit(int base, int j, int b);
    logic [7:0] s;
    s = samp[(base + j) % RN];
    return s[b];
  endfunction

  function automatic logic [2:0] slvl(int base, int j);
    return lvl[(base + j) % RN];
  endfunction

  function automatic int first_hi(int base, int n, int b);
    for (int j = 1; j <= n; j++) if (sbit(base, j, b)) return j;
    return -1;
  endfunction

  function automatic int last_hi(int base, int n, int b);
    int r;
    r = -1;
    for (int j = 1; j <= n; j++) if (sbit(base, j, b)) r = j;
    return r;
  endfunction

  function automatic int cnt_hi(int base, int n, int b);
    int r;
    r = 0;
    for (int j = 1; j <= n; j++) if (sbit(base, j, b)) r++;
    return r;
  endfunction

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_cmd(input logic [1:0] ax, input logic dr, input int st);
    cmd_axis  = ax;
    cmd_dir   = dr;
    cmd_steps = SW'(st);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_axis = 2'd0; cmd_dir = 1'b0; cmd_steps = '0;
`ifdef MOVE_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    tick(3);
    n_checks++;
    if ({x_step, x_dir, y_step, y_dir, z_step, z_dir, busy, move_done} !== 8'h00)
      $display("FAIL reset_outputs got %b want 00000000",
               {x_step, x_dir, y_step, y_dir, z_step, z_dir, busy, move_done});
    else n_pass++;
    n_checks++;
    if (fifo_level !== 3'd0) $display("FAIL reset_level got %0d want 0", fifo_level);
    else n_pass++;
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cmd_ready);
    else n_pass++;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // j = k+1 corresponds to cycle T+k, T being the push cycle.
  task automatic test_single;
    int base, v;
    base = ncyc;
    push_cmd(2'd0, 1'b1, 3);
    tick(45);
    v = first_hi(base, 46, 0);
    n_checks++; if (v != 3)  $display("FAIL single_first_step got %0d want 3", v); else n_pass++;
    v = last_hi(base, 46, 0);
    n_checks++; if (v != 32) $display("FAIL single_last_step got %0d want 32", v); else n_pass++;
    v = cnt_hi(base, 46, 0);
    n_checks++; if (v != 30) $display("FAIL single_step_len got %0d want 30", v); else n_pass++;
    v = first_hi(base, 46, 6);
    n_checks++; if (v != 32) $display("FAIL single_done_pos got %0d want 32", v); else n_pass++;
    v = cnt_hi(base, 46, 6);
    n_checks++; if (v != 1)  $display("FAIL single_done_cnt got %0d want 1", v); else n_pass++;
    n_checks++; if (sbit(base, 3, 1) !== 1'b1) $display("FAIL single_xdir got 0 want 1"); else n_pass++;
    n_checks++; if (sbit(base, 37, 7) !== 1'b1) $display("FAIL single_busy_t36 got 0 want 1"); else n_pass++;
    n_checks++; if (sbit(base, 38, 7) !== 1'b0) $display("FAIL single_busy_t37 got 1 want 0"); else n_pass++;
    v = cnt_hi(base, 46, 2) + cnt_hi(base, 46, 4);
    n_checks++; if (v != 0) $display("FAIL single_other_axes got %0d want 0", v); else n_pass++;
  endtask

  // Dwell(1) then Y(0,1) then Z(1,2), pushed on consecutive cycles.
  task automatic test_back_to_back;
    int base, v, yl, zf;
    base = ncyc;
    push_cmd(2'd3, 1'b0, 1);
    push_cmd(2'd1, 1'b0, 1);
    push_cmd(2'd2, 1'b1, 2);
    tick(60);
    n_checks++; if (slvl(base, 4) !== 3'd2) $display("FAIL b2b_level_peak got %0d want 2", slvl(base, 4)); else n_pass++;
    v = first_hi(base, 63, 2);
    n_checks++; if (v != 18) $display("FAIL b2b_y_first got %0d want 18", v); else n_pass++;
    v = cnt_hi(base, 63, 2);
    n_checks++; if (v != 10) $display("FAIL b2b_y_len got %0d want 10", v); else n_pass++;
    zf = first_hi(base, 63, 4);
    n_checks++; if (zf != 33) $display("FAIL b2b_z_first got %0d want 33", zf); else n_pass++;
    v = cnt_hi(base, 63, 4);
    n_checks++; if (v != 20) $display("FAIL b2b_z_len got %0d want 20", v); else n_pass++;
    yl = last_hi(base, 63, 2);
    n_checks++; if (zf - yl - 1 != 5) $display("FAIL b2b_gap got %0d want 5", zf - yl - 1); else n_pass++;
    n_checks++; if (sbit(base, 33, 5) !== 1'b1) $display("FAIL b2b_zdir got 0 want 1"); else n_pass++;
    n_checks++; if (slvl(base, 18) !== 3'd1) $display("FAIL b2b_level_after_y got %0d want 1", slvl(base, 18)); else n_pass++;
    n_checks++; if (slvl(base, 33) !== 3'd0) $display("FAIL b2b_level_after_z got %0d want 0", slvl(base, 33)); else n_pass++;
    v = cnt_hi(base, 63, 6);
    n_checks++; if (v != 3) $display("FAIL b2b_done_cnt got %0d want 3", v); else n_pass++;
    v = cnt_hi(base, 63, 0);
    n_checks++; if (v != 0) $display("FAIL b2b_dwell_no_x got %0d want 0", v); else n_pass++;
  endtask

  task automatic test_full_fifo;
    logic [1:0] ax [6];
    logic       dr [6];
    int         st [6];
    int         exp_len [6];
    int         got_ax [8];
    int         got_len [8];
    logic       got_dr [8];
    int base, k, waited, not_ready, ready_at_full, n, nruns, len, jj, b, ab;
    ax = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    dr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    st = '{2, 1, 1, 1, 1, 1};
    exp_len = '{20, 10, 10, 10, 10, 10};
    base = ncyc;
    k = 0; waited = 0; not_ready = 0; ready_at_full = 0;
    while (k < 6 && waited < 300) begin
      cmd_axis = ax[k]; cmd_dir = dr[k]; cmd_steps = SW'(st[k]); cmd_valid = 1'b1;
      @(negedge clk);
      if (fifo_level == 3'd4 && cmd_ready) ready_at_full++;
      if (!cmd_ready) not_ready++;
      if (cmd_ready) k++;
      @(posedge clk); #1;
      waited++;
    end
    cmd_valid = 1'b0;
    n_checks++; if (k != 6) $display("FAIL full_push_timeout got %0d pushed want 6", k); else n_pass++;
    n_checks++; if (not_ready != 22) $display("FAIL full_ready_low_cycles got %0d want 22", not_ready); else n_pass++;
    n_checks++; if (ready_at_full != 0) $display("FAIL full_ready_while_full got %0d want 0", ready_at_full); else n_pass++;
    tick(100);
    n = ncyc - base;
    nruns = 0;
    for (int j = 2; j <= n; j++) begin
      for (int a = 0; a < 3; a++) begin
        b = 2 * a;
        if (sbit(base, j, b) && !sbit(base, j - 1, b)) begin
          len = 0; jj = j;
          while (jj <= n && sbit(base, jj, b)) begin len++; jj++; end
          if (nruns < 8) begin
            got_ax[nruns] = a; got_len[nruns] = len; got_dr[nruns] = sbit(base, j, b + 1);
          end
          nruns++;
        end
      end
    end
    n_checks++; if (nruns != 6) $display("FAIL full_run_count got %0d want 6", nruns); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      if (i < nruns) begin
        ab = int'(ax[i]);
        n_checks++;
        if (got_ax[i] != ab) $display("FAIL full_order[%0d] axis got %0d want %0d", i, got_ax[i], ab); else n_pass++;
        n_checks++;
        if (got_len[i] != exp_len[i]) $display("FAIL full_len[%0d] got %0d want %0d", i, got_len[i], exp_len[i]); else n_pass++;
        n_checks++;
        if (got_dr[i] !== dr[i]) $display("FAIL full_dir[%0d] got %b want %b", i, got_dr[i], dr[i]); else n_pass++;
      end
    end
    len = cnt_hi(base, n, 6);
    n_checks++; if (len != 6) $display("FAIL full_done_cnt got %0d want 6", len); else n_pass++;
  endtask

  task automatic test_zero_dwell;
    int base, v;
    base = ncyc;
    push_cmd(2'd0, 1'b1, 0);
    push_cmd(2'd3, 1'b0, 2);
    tick(30);
    n_checks++; if (sbit(base, 2, 6) !== 1'b1) $display("FAIL zero_done_on_pop got 0 want 1"); else n_pass++;
    n_checks++; if (sbit(base, 2, 1) !== 1'b0) $display("FAIL zero_xdir_unchanged got 1 want 0"); else n_pass++;
    v = cnt_hi(base, 32, 0) + cnt_hi(base, 32, 2) + cnt_hi(base, 32, 4);
    n_checks++; if (v != 0) $display("FAIL zero_dwell_steps got %0d want 0", v); else n_pass++;
    v = last_hi(base, 32, 6);
    n_checks++; if (v != 23) $display("FAIL dwell_done_pos got %0d want 23", v); else n_pass++;
    v = cnt_hi(base, 32, 6);
    n_checks++; if (v != 2) $display("FAIL zero_dwell_done_cnt got %0d want 2", v); else n_pass++;
    n_checks++; if (sbit(base, 13, 7) !== 1'b1) $display("FAIL dwell_busy got 0 want 1"); else n_pass++;
  endtask

  task automatic test_reset_mid_move;
    int base, v;
    push_cmd(2'd0, 1'b1, 5);
    push_cmd(2'd1, 1'b0, 1);
    push_cmd(2'd2, 1'b1, 1);
    tick(7);
    n_checks++; if (x_step !== 1'b1) $display("FAIL rstmid_running got %b want 1", x_step); else n_pass++;
    n_checks++; if (fifo_level !== 3'd2) $display("FAIL rstmid_queued got %0d want 2", fifo_level); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({x_step, x_dir, y_step, y_dir, z_step, z_dir, busy, move_done} !== 8'h00)
      $display("FAIL rstmid_async_outputs got %b want 00000000",
               {x_step, x_dir, y_step, y_dir, z_step, z_dir, busy, move_done});
    else n_pass++;
    n_checks++; if (fifo_level !== 3'd0) $display("FAIL rstmid_level got %0d want 0", fifo_level); else n_pass++;
    n_checks++; if (cmd_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", cmd_ready); else n_pass++;
    tick(2);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    base = ncyc;
    tick(40);
    v = cnt_hi(base, 40, 0) + cnt_hi(base, 40, 2) + cnt_hi(base, 40, 4);
    n_checks++; if (v != 0) $display("FAIL rstmid_no_steps got %0d want 0", v); else n_pass++;
    n_checks++; if (fifo_level !== 3'd0) $display("FAIL rstmid_level_after got %0d want 0", fifo_level); else n_pass++;
    v = cnt_hi(base, 40, 7);
    n_checks++; if (v != 0) $display("FAIL rstmid_busy_after got %0d want 0", v); else n_pass++;
  endtask

`ifdef MOVE_SEQ_ABORT_EN
  task automatic test_abort;
    int base, v;
    push_cmd(2'd0, 1'b1, 5);
    push_cmd(2'd1, 1'b0, 1);
    push_cmd(2'd2, 1'b1, 1);
    tick(7);
    abort = 1'b1;
    cmd_axis = 2'd1; cmd_dir = 1'b1; cmd_steps = SW'(3); cmd_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (move_done !== 1'b0) $display("FAIL abort_done_cycle got %b want 0", move_done); else n_pass++;
    @(posedge clk); #1;
    abort = 1'b0; cmd_valid = 1'b0;
    n_checks++; if (x_step !== 1'b0) $display("FAIL abort_step_low got %b want 0", x_step); else n_pass++;
    n_checks++; if (fifo_level !== 3'd0) $display("FAIL abort_level got %0d want 0", fifo_level); else n_pass++;
    n_checks++; if (x_dir !== 1'b1) $display("FAIL abort_dir_kept got %b want 1", x_dir); else n_pass++;
    base = ncyc;
    tick(40);
    v = cnt_hi(base, 40, 6);
    n_checks++; if (v != 0) $display("FAIL abort_no_done got %0d want 0", v); else n_pass++;
    v = cnt_hi(base, 40, 0) + cnt_hi(base, 40, 2) + cnt_hi(base, 40, 4);
    n_checks++; if (v != 0) $display("FAIL abort_no_steps got %0d want 0", v); else n_pass++;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_full_fifo;
    test_zero_dwell;
    test_reset_mid_move;
`ifdef MOVE_SEQ_ABORT_EN
    test_abort;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
